// File: rtl/mul_fifo_param.sv
// Synchronous FIFO of DW-bit words; each read returns either the raw word or the
// unsigned product of its upper and lower halves, with occupancy flags and sticky errors.
module mul_fifo_param #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] DIN,
    input  logic          WR,
    input  logic          RD,
    input  logic          MODE,
    input  logic          CLR_ERR,
    output logic [DW-1:0] DOUT,
    output logic          VALID,
    output logic          FULL,
    output logic          EMPTY,
    output logic          ALMOST_FULL,
    output logic          ALMOST_EMPTY,
    output logic [AW:0]   COUNT,
    output logic          OVERFLOW,
    output logic          UNDERFLOW
);
    localparam int DEPTH = 2 ** AW;
    localparam int HW    = DW / 2;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_mode_q, rd_mode_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          full, empty, wr_ok, rd_ok;
    logic [DW-1:0] product;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        wr_ok   = WR && !full;
        rd_ok   = RD && !empty;
        product = {{HW{1'b0}}, rd_data_q[DW-1:HW]} * {{HW{1'b0}}, rd_data_q[HW-1:0]};

        wptr_d = wr_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d = rd_ok ? rptr_q + AW'(1) : rptr_q;

        count_d = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // Popped word and its MODE are staged one cycle; DOUT is formed from the stage.
        rd_pend_d = rd_ok;
        rd_data_d = rd_ok ? mem[rptr_q] : rd_data_q;
        rd_mode_d = rd_ok ? MODE : rd_mode_q;

        valid_d = rd_pend_q;
        dout_d  = dout_q;
        if (rd_pend_q) begin
            dout_d = rd_mode_q ? product : rd_data_q;
        end

        // A new error in the same cycle wins over the clear.
        ovf_d = (WR && full)  ? 1'b1 : (CLR_ERR ? 1'b0 : ovf_q);
        unf_d = (RD && empty) ? 1'b1 : (CLR_ERR ? 1'b0 : unf_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            rd_mode_q <= 1'b0;
            rd_pend_q <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            rd_mode_q <= rd_mode_d;
            rd_pend_q <= rd_pend_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem[wptr_q] <= DIN;
        end
    end

    assign DOUT         = dout_q;
    assign VALID        = valid_q;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count_q >= (AW+1)'(AF_LEVEL));
    assign ALMOST_EMPTY = (count_q <= (AW+1)'(AE_LEVEL));
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_mul_fifo_param.sv
// Bench for mul_fifo_param (DW=16, AW=4): hand-computed vector table, directed
// corner sequences and a random phase, all checked against a queue-based model.
module tb_mul_fifo_param;
    logic        clk = 1'b0;
    logic        rst, wr, rd, mode, clr_err;
    logic [15:0] din;
    logic [15:0] dout;
    logic        valid, full, empty, afull, aempty, ovf, unf;
    logic [4:0]  count;

    mul_fifo_param #(.DW(16), .AW(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .WR(wr), .RD(rd), .MODE(mode), .CLR_ERR(clr_err),
        .DOUT(dout), .VALID(valid), .FULL(full), .EMPTY(empty), .ALMOST_FULL(afull),
        .ALMOST_EMPTY(aempty), .COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(unf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: stored words, one-deep read pipeline, visible outputs.
    logic [15:0] q[$];
    logic [15:0] got[$];
    logic        m_pend = 1'b0;
    logic [15:0] m_pend_val = '0;
    logic [15:0] m_dout = '0;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd_i, input logic m,
                        input logic c, input logic [15:0] d);
        logic        full_m, empty_m;
        logic [15:0] word;
        rst = r; wr = w; rd = rd_i; mode = m; clr_err = c; din = d;
        if (r) begin
            q.delete();
            m_pend = 0; m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            full_m  = (q.size() == 16);
            empty_m = (q.size() == 0);
            m_valid = m_pend;
            if (m_pend) m_dout = m_pend_val;
            m_pend = 0;
            if (rd_i && !empty_m) begin
                word = q.pop_front();
                m_pend_val = m ? word[15:8] * word[7:0] : word;
                m_pend = 1;
            end
            if (w && !full_m) q.push_back(d);
            m_ovf = (w && full_m)     ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = (rd_i && empty_m) ? 1'b1 : (c ? 1'b0 : m_unf);
        end
        @(posedge clk);
        #1;
        chk("count",        32'(count),  32'(q.size()));
        chk("full",         32'(full),   32'(q.size() == 16));
        chk("empty",        32'(empty),  32'(q.size() == 0));
        chk("almost_full",  32'(afull),  32'(q.size() >= 14));
        chk("almost_empty", 32'(aempty), 32'(q.size() <= 2));
        chk("valid",        32'(valid),  32'(m_valid));
        chk("dout",         32'(dout),   32'(m_dout));
        chk("overflow",     32'(ovf),    32'(m_ovf));
        chk("underflow",    32'(unf),    32'(m_unf));
        if (valid) got.push_back(dout);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 16'h0);
    endtask

    typedef struct {
        logic        wr, rd, mode, clr;
        logic [15:0] din;
        logic [4:0]  e_count;
        logic        e_valid;
        logic [15:0] e_dout;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int vcnt, nxt, budget;
        logic w_i, r_i, acc;

        // wr rd mode clr din | count valid dout ovf unf  (starting from reset, empty)
        vecs[0] = '{0, 1, 0, 0, 16'h0000, 5'd0, 0, 16'h0000, 0, 1};
        vecs[1] = '{0, 0, 0, 1, 16'h0000, 5'd0, 0, 16'h0000, 0, 0};
        vecs[2] = '{0, 1, 0, 1, 16'h0000, 5'd0, 0, 16'h0000, 0, 1};
        vecs[3] = '{1, 1, 0, 0, 16'h1234, 5'd1, 0, 16'h0000, 0, 1};
        vecs[4] = '{0, 1, 0, 1, 16'h0000, 5'd0, 0, 16'h0000, 0, 0};
        vecs[5] = '{1, 0, 0, 0, 16'h0304, 5'd1, 1, 16'h1234, 0, 0};
        vecs[6] = '{0, 1, 1, 0, 16'h0000, 5'd0, 0, 16'h1234, 0, 0};
        vecs[7] = '{0, 0, 0, 0, 16'h0000, 5'd0, 1, 16'h000c, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 16'h0000, 5'd0, 0, 16'h000c, 0, 0};

        step(1, 0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_aempty", 32'(aempty), 1);

        for (int i = 0; i < 9; i++) begin
            step(0, vecs[i].wr, vecs[i].rd, vecs[i].mode, vecs[i].clr, vecs[i].din);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_dout", i),  32'(dout),  32'(vecs[i].e_dout));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_unf", i),   32'(unf),   32'(vecs[i].e_unf));
        end

        // Fill with 0x5a5a, then one write too many.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 0, 16'h5a5a);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        step(0, 1, 0, 1, 0, 16'h5a5a);
        chk("fill_overflow", 32'(ovf), 1);
        chk("fill_count_hold", 32'(count), 16);

        // Drain in product mode: 0x5a * 0x5a = 0x1fa4.
        vcnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) step(0, 0, 1, 1, 0, 16'h0);
            else idle();
            if (valid && dout == 16'h1fa4) vcnt++;
        end
        chk("drain_valid_cycles", 32'(vcnt), 16);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_dout_hold", 32'(dout), 32'h1fa4);
        step(0, 0, 0, 0, 1, 16'h0);

        // 20 sequential words with random reads, wrapping the pointers.
        got.delete();
        nxt = 1;
        budget = 0;
        while ((nxt <= 20 || q.size() > 0 || m_pend) && budget < 400) begin
            w_i = (nxt <= 20);
            r_i = (nxt > 20) || ($urandom_range(0, 2) == 0);
            acc = w_i && (q.size() < 16);
            step(0, w_i, r_i, 0, 0, 16'(nxt));
            if (acc) nxt++;
            budget++;
        end
        idle();
        chk("seq_words_out", 32'(got.size()), 20);
        for (int i = 0; i < got.size() && i < 20; i++)
            chk($sformatf("seq_word%0d", i), 32'(got[i]), 32'(i + 1));
        step(0, 0, 0, 0, 1, 16'h0);

        // Hold COUNT at 8 with simultaneous WR & RD.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 16'(16'h100 + i));
        got.delete();
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 16'(16'h200 + i));
        chk("hold_count", 32'(count), 8);
        idle();
        chk("hold_valids", 32'(got.size()), 10);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 16'($urandom));
        for (int i = 0; i < 18; i++) step(0, 0, 1, 0, 0, 16'h0);

        // Reset at COUNT=9 with VALID high; new data only afterwards.
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 16'(16'h300 + i));
        step(0, 0, 1, 0, 0, 16'h0);
        idle();
        chk("pre_rst_count", 32'(count), 9);
        chk("pre_rst_valid", 32'(valid), 1);
        step(1, 0, 0, 0, 0, 16'h0);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_dout", 32'(dout), 0);
        step(0, 1, 0, 0, 0, 16'hbeef);
        step(0, 0, 1, 0, 0, 16'h0);
        idle();
        chk("post_rst_data", 32'(dout), 32'hbeef);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
